// File: rtl/barrel_pkg.sv
// Shared constants and reference rotate helpers for the pipelined rotate-left unit.
package barrel_pkg;

  // Default datapath width and the matching rotate-amount field width.
  localparam int BARREL_WIDTH = 8;
  localparam int BARREL_AMT_W = $clog2(BARREL_WIDTH);

  // Rotate left by amt: bits leaving the MSB re-enter at the LSB.
  function automatic logic [BARREL_WIDTH-1:0] rotl(
    input logic [BARREL_WIDTH-1:0] data,
    input logic [BARREL_AMT_W-1:0] amt
  );
    return (data << amt) | (data >> (BARREL_WIDTH - int'(amt)));
  endfunction

  // Rotate right by amt; rotl(rotr(x, n), n) == x for every n.
  function automatic logic [BARREL_WIDTH-1:0] rotr(
    input logic [BARREL_WIDTH-1:0] data,
    input logic [BARREL_AMT_W-1:0] amt
  );
    return (data >> amt) | (data << (BARREL_WIDTH - int'(amt)));
  endfunction

endpackage

// File: rtl/rotl_stage.sv
// One register stage of the rotate-left pipeline: fixed rotate by 2^STAGE when
// the travelling amount has bit STAGE set, plus the local valid/ready logic.
module rotl_stage #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  output logic             o_ready,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [AMT_W-1:0] o_amt
);

  // Rotate distance of this stage; always strictly less than WIDTH.
  localparam int SHIFT = 1 << STAGE;

  logic [WIDTH-1:0] w_rot;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_amt;

  // Conditional fixed rotate; pure wiring when the amount bit is clear.
  assign w_rot = i_amt[STAGE] ? ((i_data << SHIFT) | (i_data >> (WIDTH - SHIFT)))
                              : i_data;

  // The stage can take a new entry when it is empty or its content moves on.
  assign o_ready = !r_valid || i_ready;

  // Stage registers: load (including bubbles) when ready, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      r_data  <= w_rot;
      r_amt   <= i_amt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_amt   = r_amt;

endmodule

// File: rtl/barrel_rotl_pipe.sv
// Pipelined logarithmic rotate-left unit with valid/ready on both sides.
// One register stage per amount bit; stage k applies the 2^k rotate.
// WIDTH must be a power of two, at least 2.
module barrel_rotl_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH = BARREL_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt
);

  // Index k is the input of stage k; index AMT_W is the pipeline output.
  logic             w_valid [0:AMT_W];
  logic [WIDTH-1:0] w_data  [0:AMT_W];
  logic [AMT_W-1:0] w_amt   [0:AMT_W];
  logic             w_ready [0:AMT_W];

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_data;
  assign w_amt[0]       = in_amt;
  assign w_ready[AMT_W] = out_ready;

  // Chain of stages; ready ripples combinationally back from out_ready.
  generate
    for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
      rotl_stage #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W),
        .STAGE (gi)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_valid[gi]),
        .i_data  (w_data[gi]),
        .i_amt   (w_amt[gi]),
        .o_ready (w_ready[gi]),
        .i_ready (w_ready[gi+1]),
        .o_valid (w_valid[gi+1]),
        .o_data  (w_data[gi+1]),
        .o_amt   (w_amt[gi+1])
      );
    end
  endgenerate

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[AMT_W];
  assign out_data  = w_data[AMT_W];
  assign out_amt   = w_amt[AMT_W];

endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Self-checking bench for barrel_rotl_pipe (WIDTH=8): table sweep, random
// round trips, back-pressure, bubbles, mid-flight reset and full-rate streaming.
module tb_barrel_rotl_pipe;
  import barrel_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_amt;

  barrel_rotl_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_amt   (out_amt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] amt;
    int            acc_cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] amt;
    logic [W-1:0]  exp;
  } vec_t;

  exp_t          q[$];
  vec_t          sweep [8];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_out = 0;
  logic          last_in_fire = 1'b0;
  logic          last_out_valid = 1'b0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data = '0;
  logic [AW-1:0] prev_amt = '0;
  logic [W-1:0]  cur_exp = '0;
  logic          chk_lat = 1'b0;
  logic          rand_ready = 1'b0;

  // Reference: bit i of the operand lands at position (i + amt) mod W.
  function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] d, input int a);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[(i + a) % W] = d[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_in_fire   = in_valid && in_ready;
    last_out_valid = out_valid;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_data));
      check("hold_amt", 32'(out_amt), 32'(prev_amt));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out act=%02h exp=no_pending_transaction (cycle %0d)", out_data, cyc);
      end else begin
        e = q.pop_front();
        $display("OUT cycle=%0d data=%02h amt=%0d exp_data=%02h", cyc, out_data, out_amt, e.data);
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_amt", 32'(out_amt), 32'(e.amt));
        if (chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(AW));
        n_out++;
      end
    end
    if (last_in_fire) begin
      q.push_back('{cur_exp, in_amt, cyc});
      $display("IN  cycle=%0d data=%02h amt=%0d", cyc, in_data, in_amt);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_amt   = out_amt;
    cyc++;
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one transaction and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a,
                      input logic [W-1:0] x, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    cur_exp  = x;
    waited   = 0;
    cycle();
    waited++;
    while (!last_in_fire && waited < 200) begin
      cycle();
      waited++;
    end
    if (!last_in_fire) begin
      checks++;
      errors++;
      $display("FAIL send_timeout act=not_accepted exp=accepted (cycle %0d)", cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    in_data  = 'x;
    in_amt   = 'x;
    while (q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout act=%0d_pending exp=0_pending", q.size());
    end
  endtask

  initial begin
    int            w;
    int            base;
    int            idx;
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic [W-1:0]  bp_val [5];
    logic [AW-1:0] bp_amt [5];
    int            pat [8];

    for (int i = 0; i < 8; i++) begin
      sweep[i].data = 8'b0000_0011;
      sweep[i].amt  = 3'(i);
    end
    sweep[0].exp = 8'b0000_0011;
    sweep[1].exp = 8'b0000_0110;
    sweep[2].exp = 8'b0000_1100;
    sweep[3].exp = 8'b0001_1000;
    sweep[4].exp = 8'b0011_0000;
    sweep[5].exp = 8'b0110_0000;
    sweep[6].exp = 8'b1100_0000;
    sweep[7].exp = 8'b1000_0001;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b1;

    // Reset state while held in reset.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_amt", 32'(out_amt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Amount sweep, back-to-back, full rate.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(sweep[i].data, sweep[i].amt, sweep[i].exp, w);
      check("sweep_accept_wait", 32'(w), 32'd1);
    end
    drain();

    // Bubbles: valid pattern 1,0,1,0 must reappear at the output three cycles later.
    pat = '{1, 0, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      in_valid = pat[i][0];
      if (i == 0) begin
        in_data = 8'h81; in_amt = 3'd1; cur_exp = 8'h03;
      end else if (i == 2) begin
        in_data = 8'h0F; in_amt = 3'd4; cur_exp = 8'hF0;
      end else begin
        in_data = 'x; in_amt = 'x;
      end
      cycle();
      check("bubble_out_valid", 32'(last_out_valid), (i >= 3) ? 32'(pat[i-3]) : 32'd0);
    end
    drain();

    // Back-pressure: out_ready low for 6 cycles while streaming five values.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    bp_val[0] = 8'b1011_0001;
    bp_amt[0] = 3'd3;
    for (int i = 1; i < 5; i++) begin
      bp_val[i] = 8'($urandom);
      bp_amt[i] = 3'($urandom_range(0, 7));
    end
    base = n_out;
    idx  = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = bp_val[idx];
      in_amt   = bp_amt[idx];
      cur_exp  = ref_rotl(bp_val[idx], int'(bp_amt[idx]));
      cycle();
      if (last_in_fire) idx++;
    end
    check("bp_accepts", 32'(idx), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'h8D);
    out_ready = 1'b1;
    while (idx < 5) begin
      send(bp_val[idx], bp_amt[idx], ref_rotl(bp_val[idx], int'(bp_amt[idx])), w);
      idx++;
    end
    drain();
    check("bp_emitted", 32'(n_out - base), 32'd5);

    // Reset mid-flight with three transactions parked in the pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      a = 3'($urandom_range(0, 7));
      send(d, a, ref_rotl(d, int'(a)), w);
    end
    in_valid = 1'b0;
    check("pre_rst_full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_amt", 32'(out_amt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    q.delete();
    prev_stall = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("post_rst_quiet", 32'(last_out_valid), 32'd0);
    end
    chk_lat = 1'b1;
    send(8'h01, 3'd7, 8'h80, w);
    drain();

    // Full-rate streaming: 20 transactions, simultaneous accept and emit.
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      a = 3'($urandom_range(0, 7));
      send(d, a, ref_rotl(d, int'(a)), w);
      check("stream_accept_wait", 32'(w), 32'd1);
    end
    drain();
    check("stream_emitted", 32'(n_out - base), 32'd20);

    // Round trip through the right rotator, with random downstream stalls and gaps.
    chk_lat    = 1'b0;
    rand_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 50; i++) begin
      d = 8'($urandom);
      a = 3'($urandom_range(0, 7));
      send(rotr(d, a), a, d, w);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        cycle();
      end
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check("roundtrip_emitted", 32'(n_out - base), 32'd50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/barrel_rotl_pipe.md
Name: barrel_rotl_pipe

Overview:
Pipelined rotate-left unit. It is the inverse direction of the team's combinational 8-bit rotate-right barrel shifter, so a value rotated right by N and then fed through this block with the same N returns unchanged. Logarithmic structure: one register stage per amount bit, with a valid/ready handshake on both sides. Sits on datapaths that need a registered, back-pressurable rotator at full throughput.

Parameters:
WIDTH, 8, data width in bits; must be a power of two, minimum 2.
AMT_W, $clog2(WIDTH), width of the rotate-amount field; derived, not overridden.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a transaction
in_ready  output  1  block can accept a transaction this cycle
in_data  input  WIDTH  operand
in_amt  input  AMT_W  rotate-left amount, 0..WIDTH-1
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream accepts the result this cycle
out_data  output  WIDTH  in_data rotated left by in_amt
out_amt  output  AMT_W  in_amt echoed alongside its result

Behaviour:
- Stage k (k = 0..AMT_W-1) registers valid_k, data_k and amt_k.
  - It rotates its input left by 2^k when amt bit k is 1; otherwise it passes the input through.
  - Stage 0 takes in_data/in_amt. The last stage drives out_data/out_amt/out_valid.
- Rotation is modular. Bits shifted out of the MSB re-enter at the LSB. No bit is lost; no sign or zero fill.
- Latency: a transaction accepted at edge T appears with out_valid=1 after edge T+AMT_W-1, i.e. 3 cycles for WIDTH=8 when there is no back-pressure.
- Throughput: one transaction per cycle while out_ready=1.
- Handshake:
  - Transfer occurs on an edge where valid and ready are both 1.
  - ready_k = !valid_k || ready_(k+1). ready of the last stage = !out_valid || out_ready. in_ready = ready_0.
  - in_ready may depend combinationally on out_ready.
- Stage update when ready_k=1: it loads the previous stage's valid/data/amt (a bubble loads valid=0).
- Stage hold when ready_k=0: all of its registers hold.
- While out_valid=1 and out_ready=0, out_data and out_amt are stable.
- Full pipeline with out_ready=0: in_ready=0 and in_data is ignored.
- Simultaneous accept and emit on a full pipeline with out_ready=1: the pipeline advances, in_ready=1, no transaction is dropped or duplicated.
- in_valid=0: a bubble enters. Bubbles collapse when a later stage is empty.
- Reset:
  - Asynchronous assertion clears every valid_k, data_k and amt_k to 0 immediately.
  - So out_valid=0, out_data=0, out_amt=0, and in_ready=1 whenever rst_n=0.
  - In-flight transactions are discarded; nothing is emitted after reset release until new input.
- amt=0: data passes through unchanged, with the same latency.
- X on in_data/in_amt while in_valid=0 must not propagate to out_valid.

Decomposition:
- Package barrel_pkg:
  - WIDTH default constant.
  - AMT_W derivation.
  - Function rotl(data, amt) used as the golden model by the bench.
  - Function rotr(data, amt) for round-trip checks against the right rotator.
- Sub-module rotl_stage (parameters WIDTH, AMT_W, STAGE):
  - Contains one register stage with its fixed 2^STAGE rotate and its local ready logic.
  - Instantiated AMT_W times by a generate loop in barrel_rotl_pipe.

Test Plan:
- Amount sweep, out_ready=1: in_data=8'b00000011, in_amt=0..7 back-to-back -> out_data in order 00000011, 00000110, 00001100, 00011000, 00110000, 01100000, 11000000, 10000001, first result 3 cycles after first accept, one per cycle after that.
- Round trip: for 50 random data/amt pairs, feed rotr(data,amt) with the same amt -> out_data == data and out_amt == amt every time.
- Back-pressure: stream 10110001 with amt=3, then 4 more values, with out_ready=0 for 6 cycles -> in_ready drops to 0 after 3 accepts; out_data=10001101 held stable; after out_ready=1 all 5 results emerge in order, none lost or duplicated.
- Bubbles: in_valid toggled 1,0,1,0 with data 0x81 amt=1 and 0x0F amt=4 -> outputs 0x03 then 0xF0, out_valid pattern mirrors the input spacing.
- Reset mid-flight: 3 transactions in the pipe, pulse rst_n low between edges -> out_valid=0 and out_data=0 immediately, in_ready=1; no stale output after release; the next input 0x01 amt=7 yields 0x80.
- Simultaneous accept/emit on a full pipe with out_ready=1 and in_valid=1 for 20 cycles -> exactly 20 results, matching rotl.
